// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: performs the data-memory access for rmmovq,
// mrmovq, pushq, popq, call and ret, and tracks the processor status code.
// The access is held in ACCESS for ACCESS_LAT cycles before it commits.
// Optional build macro: MEM_ALIGN_CHECK_EN (fault on unaligned addresses).
module memory_stage #(
    parameter int MEM_BYTES  = 8192,
    parameter int ACCESS_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    logic [3:0]  icode_q;
    logic [63:0] vale_q;
    logic [63:0] vala_q;
    logic [63:0] valp_q;

    logic [7:0]  mem [0:MEM_BYTES-1];

    logic [63:0]   addr;
    logic [AW-1:0] base;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic          fault;
    logic          access_edge;
    logic          wr_en;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    function automatic logic is_mem_op(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    // mrmovq, ret, popq load from memory; the remaining memory ops store
    function automatic logic is_read_op(input logic [3:0] ic);
        return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    endfunction

    // ret and popq address through the old stack pointer held in valA
    function automatic logic uses_vala_addr(input logic [3:0] ic);
        return (ic == 4'h9) || (ic == 4'hB);
    endfunction

    // An 8-byte access must fit entirely inside the array; any address past
    // MAX_ADDR (including ones whose +7 would wrap) is rejected
    function automatic logic addr_fault(input logic [63:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (a > MAX_ADDR) || (a[2:0] != 3'b000);
`else
        return (a > MAX_ADDR);
`endif
    endfunction

    // Address, write data and fault detection from the latched operands
    always_comb begin
        addr        = uses_vala_addr(icode_q) ? vala_q : vale_q;
        base        = addr[AW-1:0];
        wdata       = (icode_q == 4'h8) ? valp_q : vala_q;
        fault       = addr_fault(addr);
        access_edge = (state == ACCESS) && (count == '0);
        wr_en       = access_edge && !is_read_op(icode_q) && !fault && !rst;
    end

    // Little-endian 8-byte read starting at base
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    // Control FSM with registered valM, stat, busy and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            valM  <= '0;
            stat  <= STAT_AOK;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && (stat == STAT_AOK)) begin
                        if (is_mem_op(icode)) begin
                            state <= ACCESS;
                            count <= CW'(ACCESS_LAT - 1);
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            if (icode == 4'h0) begin
                                stat <= STAT_HLT;
                            end else if (icode > 4'hB) begin
                                stat <= STAT_INS;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (fault) begin
                            stat <= STAT_ADR;
                        end else if (is_read_op(icode_q)) begin
                            valM <= rdata;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on an accepted start; inputs are free to change after
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start && (stat == STAT_AOK)) begin
            icode_q <= icode;
            vale_q  <= valE;
            vala_q  <= valA;
            valp_q  <= valP;
        end
    end

    // Little-endian 8-byte store; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (ACCESS_LAT = 2, 8 KiB).
// Expected values are hand-computed from the Y86-64 memory stage behaviour.
module tb_memory_stage;

    localparam int MEM_BYTES  = 8192;
    localparam int ACCESS_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [63:0] valE = '0;
    logic [63:0] valA = '0;
    logic [63:0] valP = '0;
    logic [63:0] valM;
    logic [2:0]  stat;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .ACCESS_LAT(ACCESS_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .valM(valM), .stat(stat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Issue one op; edges = start-edge-to-done count, or -1 if no done in budget
    task automatic run_op(input logic [3:0] ic, input logic [63:0] e,
                          input logic [63:0] a, input logic [63:0] p,
                          output int edges, output int busy_cyc);
        @(posedge clk); #1;
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        icode = 4'h5; valE = 64'hFFFF_0000_FFFF_0000;
        valA = 64'h0BAD_0BAD_0BAD_0BAD; valP = 64'h1;
        edges = 1;
        busy_cyc = 0;
        while ((done !== 1'b1) && (edges <= 8)) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
        if (done !== 1'b1) edges = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (valM !== 64'h0) $display("FAIL reset_valM: got %h want 0", valM); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL reset_stat: got %0d want 1", stat); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        #10 rst = 1'b0;
    endtask

    task automatic test_rmmovq_mrmovq();
        int ed, bc;
        run_op(4'h4, 64'h100, 64'h1122_3344_5566_7788, 64'h0, ed, bc);
        total++; if (ed !== 3) $display("FAIL rmmovq_latency: got %0d want 3", ed); else passed++;
        total++; if (bc !== 2) $display("FAIL rmmovq_busy_cycles: got %0d want 2", bc); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL rmmovq_stat: got %0d want 1", stat); else passed++;
        // Zero the bytes just above so the unaligned read sees known data
        run_op(4'h4, 64'h108, 64'h0, 64'h0, ed, bc);
        run_op(4'h5, 64'h100, 64'h0, 64'h0, ed, bc);
        total++; if (valM !== 64'h1122_3344_5566_7788) $display("FAIL mrmovq_read: got %h want 1122334455667788", valM); else passed++;
        total++; if (ed !== 3) $display("FAIL mrmovq_latency: got %0d want 3", ed); else passed++;
`ifndef MEM_ALIGN_CHECK_EN
        run_op(4'h5, 64'h103, 64'h0, 64'h0, ed, bc);
        total++; if (valM !== 64'h0000_0011_2233_4455) $display("FAIL mrmovq_unaligned: got %h want 0000001122334455", valM); else passed++;
`endif
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        icode = 4'h4; valE = 64'h300; valA = 64'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (valM !== 64'h0) $display("FAIL async_rst_valM: got %h want 0", valM); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL async_rst_stat: got %0d want 1", stat); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL async_rst_done: got %b want 0", done); else passed++;
        #1 rst = 1'b0;
    endtask

    task automatic test_call_ret();
        int ed, bc;
        run_op(4'h8, 64'h1F8, 64'h0, 64'h40, ed, bc);
        run_op(4'h9, 64'h500, 64'h1F8, 64'h0, ed, bc);
        total++; if (valM !== 64'h40) $display("FAIL ret_valM: got %h want 40", valM); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL call_ret_stat: got %0d want 1", stat); else passed++;
    endtask

    task automatic test_push_pop();
        int ed, bc;
        run_op(4'hA, 64'h1F0, 64'hCAFE, 64'h0, ed, bc);
        run_op(4'hB, 64'h600, 64'h1F0, 64'h0, ed, bc);
        total++; if (valM !== 64'hCAFE) $display("FAIL popq_valM: got %h want cafe", valM); else passed++;
    endtask

    task automatic test_non_mem();
        int ed, bc;
        run_op(4'h6, 64'h123, 64'h456, 64'h0, ed, bc);
        total++; if (ed !== 1) $display("FAIL opq_latency: got %0d want 1", ed); else passed++;
        total++; if (valM !== 64'hCAFE) $display("FAIL opq_valM: got %h want cafe", valM); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL opq_stat: got %0d want 1", stat); else passed++;
    endtask

    task automatic test_bounds();
        int ed, bc;
        run_op(4'h4, 64'(MEM_BYTES - 8), 64'hA5A5_0123_4567_89AB, 64'h0, ed, bc);
        run_op(4'h5, 64'(MEM_BYTES - 8), 64'h0, 64'h0, ed, bc);
        total++; if (valM !== 64'hA5A5_0123_4567_89AB) $display("FAIL top_word_read: got %h want a5a50123456789ab", valM); else passed++;
        total++; if (stat !== 3'd1) $display("FAIL top_word_stat: got %0d want 1", stat); else passed++;
        run_op(4'h5, 64'(MEM_BYTES - 4), 64'h0, 64'h0, ed, bc);
        total++; if (stat !== 3'd3) $display("FAIL oob_stat: got %0d want 3", stat); else passed++;
        total++; if (valM !== 64'hA5A5_0123_4567_89AB) $display("FAIL oob_valM: got %h want a5a50123456789ab", valM); else passed++;
        total++; if (ed !== 3) $display("FAIL oob_latency: got %0d want 3", ed); else passed++;
        run_op(4'h5, 64'h100, 64'h0, 64'h0, ed, bc);
        total++; if (ed !== -1) $display("FAIL sticky_no_done: got %0d want -1", ed); else passed++;
        total++; if (stat !== 3'd3) $display("FAIL sticky_stat: got %0d want 3", stat); else passed++;
        do_reset();
        run_op(4'h5, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'h0, ed, bc);
        total++; if (stat !== 3'd3) $display("FAIL wrap_stat: got %0d want 3", stat); else passed++;
        total++; if (valM !== 64'h0) $display("FAIL wrap_valM: got %h want 0", valM); else passed++;
    endtask

    task automatic test_halt_ins();
        int ed, bc;
        do_reset();
        run_op(4'h0, 64'h0, 64'h0, 64'h0, ed, bc);
        total++; if (ed !== 1) $display("FAIL halt_latency: got %0d want 1", ed); else passed++;
        total++; if (stat !== 3'd2) $display("FAIL halt_stat: got %0d want 2", stat); else passed++;
        do_reset();
        run_op(4'hC, 64'h0, 64'h0, 64'h0, ed, bc);
        total++; if (ed !== 1) $display("FAIL ins_latency: got %0d want 1", ed); else passed++;
        total++; if (stat !== 3'd4) $display("FAIL ins_stat: got %0d want 4", stat); else passed++;
    endtask

    task automatic test_reset_final_cycle();
        int ed, bc;
        do_reset();
        run_op(4'h4, 64'h200, 64'h0123_4567_89AB_CDEF, 64'h0, ed, bc);
        @(posedge clk); #1;
        icode = 4'h4; valE = 64'h200; valA = 64'hDEAD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else passed++;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b want 0", busy); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'h5, 64'h200, 64'h0, 64'h0, ed, bc);
        total++; if (valM !== 64'h0123_4567_89AB_CDEF) $display("FAIL abort_no_write: got %h want 0123456789abcdef", valM); else passed++;
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        int ed, bc;
        do_reset();
        run_op(4'h5, 64'h101, 64'h0, 64'h0, ed, bc);
        total++; if (stat !== 3'd3) $display("FAIL align_stat: got %0d want 3", stat); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_rmmovq_mrmovq();
        test_async_reset();
        test_call_ret();
        test_push_pop();
        test_non_mem();
        test_bounds();
        test_halt_ins();
        test_reset_final_cycle();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 SEQ memory stage, directly downstream of the execute stage.
- Consumes icode, valE, valA and valP; performs the data-memory access for rmmovq, mrmovq, pushq, popq, call and ret.
- Produces valM and the processor status code.
- Internal byte-addressed data memory with a configurable multi-cycle access latency; start/busy/done handshake with the sequencer.

Parameters:
- MEM_BYTES, 8192, data memory size in bytes.
- ACCESS_LAT, 2, cycles spent in ACCESS per memory op; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- icode  input  4  instruction code from execute
- valE  input  64  ALU result (address for rmmovq/mrmovq/pushq/call)
- valA  input  64  write data (rmmovq/pushq); address for popq/ret
- valP  input  64  return address written by call
- valM  output  64  read data
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  output  1  high in ACCESS
- done  output  1  one-cycle completion pulse

Behaviour:
- One clock, clk. Asynchronous active-high reset, rst.
- Reset values: valM=0, stat=1, busy=0, done=0, state=IDLE, counter=0. Memory contents are not cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start=1 and stat=AOK: latch icode, valE, valA and valP.
  - Memory op (icode 4,5,8,9,A,B) -> ACCESS, counter=ACCESS_LAT-1, busy=1.
  - Any other icode -> DONE.
  - start=1 with stat!=AOK: ignored; stays in IDLE and no done pulse.
- ACCESS:
  - Each edge decrements counter. Inputs may change freely; only latched values are used.
  - Edge with counter==0: perform the access, busy=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency from the start edge to done high:
  - Memory op: ACCESS_LAT+1 edges.
  - Non-memory op: 1 edge.
- Address selection: popq and ret use valA; all other memory ops use valE.
- Write data: call writes valP; rmmovq and pushq write valA.
- Read ops: mrmovq, popq, ret.
- Access width: 8 bytes, little-endian; addr is the least significant byte.
- Bounds: if addr > MEM_BYTES-8 (unsigned 64-bit compare; addr+7 overflow counts as out of range):
  - No write; valM unchanged; stat=3 at the access edge.
- Reads update valM only on a successful access. Writes leave valM unchanged.
- icode 0 (halt): stat=2 at the DONE transition.
- icode > 0xB: stat=4 at the DONE transition.
- Other non-memory icodes (1,2,3,6,7): stat stays 1 and valM is unchanged.
- stat is sticky until reset.
- Reset during ACCESS, including the final cycle, aborts with no memory write. Reset has priority over the access edge.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: a memory op whose address[2:0]!=0 is treated like an out-of-range access (no write, stat=3), reported at the access edge.
- Not defined: unaligned addresses are accessed byte-wise with no fault.

Test Plan:
- rst=1 mid-run, then release -> valM=0, stat=1, busy=0, done=0 immediately on assertion, without a clock edge.
- rmmovq (icode 4), valE=0x100, valA=0x1122334455667788, ACCESS_LAT=2:
  - busy high for 2 cycles; done pulses 3 edges after start.
  - Then mrmovq (icode 5), valE=0x100 -> valM=0x1122334455667788.
  - Then mrmovq at valE=0x103 -> valM=0x0000001122334455 with memory above 0x107 zero-initialised (feature off).
- call (icode 8), valE=0x1F8, valP=0x40, then ret (icode 9), valA=0x1F8 -> valM=0x40. stat stays 1.
- mrmovq, valE=MEM_BYTES-4:
  - stat=3 and valM unchanged.
  - Subsequent start with icode 5 -> no done pulse; stat stays 3.
- icode 0 -> done after 1 edge, stat=2. Fresh run, icode 0xC -> stat=4.
- Reset asserted in the final ACCESS cycle of rmmovq valE=0x200, valA=0xDEAD -> after release, mrmovq valE=0x200 returns the prior contents (0 with memory preloaded to 0).
- MEM_ALIGN_CHECK_EN defined: mrmovq valE=0x101 -> stat=3.
